rr_token_arb: RTL
=================

RR_TOKEN_ARB -- requirements
Module: rr_token_arb

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum grant length in cycles, used only when RR_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 ck  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  reset; synchronous to ck, active-high.
REQ-004 req  input  4  request per requester; requester i holds req[i] high for as long as it uses the shared resource.
REQ-005 gnt  output  4  one-hot grant, or all zeros; registered.
REQ-006 gnt_id  output  2  index of the granted requester; valid while busy=1, 0 otherwise; registered.
REQ-007 busy  output  1  high while any gnt bit is high; registered.
REQ-008 timeout  output  1  one-cycle pulse on a forced revoke; registered.

Function
REQ-009 The block SHALL hold a 4-bit one-hot token register tok that marks the highest-priority requester.
REQ-010 The block SHALL use two states, IDLE and GRANT.
REQ-011 Winner selection SHALL be the first i with req[i]=1, searched in ring order tok, tok+1, tok+2, tok+3, wrapping 3->0.
REQ-012 In IDLE with req≠0 at an edge, that edge SHALL set gnt to the winner and gnt_id to its index, set busy=1, and enter GRANT: one cycle from request to grant.
REQ-013 In IDLE with req=0, gnt, busy and tok SHALL be unchanged.
REQ-014 In GRANT while req[gnt_id]=1, gnt and gnt_id SHALL be held, whatever the other req bits do.
REQ-015 In GRANT when req[gnt_id]=0 at an edge, tok SHALL become one-hot at gnt_id+1 mod 4, and the next winner SHALL be selected with the updated tok.
REQ-016 Release SHALL hand over on the same edge with no dead cycle: if another request is pending, gnt goes straight to it and the state stays GRANT; otherwise gnt=0, busy=0 and the state becomes IDLE.
REQ-017 A released requester that re-asserts req SHALL get lowest priority for the next selection; it is never granted twice in a row while another requester is pending.
REQ-018 gnt SHALL never have more than one bit set, and gnt[i]=1 SHALL imply req[i] was 1 at the granting edge.
REQ-019 tok SHALL change only on release or on forced revoke, never in IDLE.
REQ-020 A requester whose req drops before being granted SHALL simply not be selected; no request is stored internally.

Reset
REQ-021 rst=1 at an edge SHALL set state=IDLE, tok=4'b0001, gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0.
REQ-022 Reset SHALL take priority over every other event, including reset during GRANT, which revokes the grant at that edge.
REQ-023 The first edge after rst falls SHALL arbitrate normally, with requester 0 highest priority.

Configuration
REQ-024 Macro RR_TIMEOUT_EN SHALL compile in the grant-length limit.
REQ-025 With RR_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on every new grant, including a handover, and increment each GRANT cycle.
REQ-026 With RR_TIMEOUT_EN defined, when the counter reaches HOLD_MAX-1 with req[gnt_id] still high, the next edge SHALL treat the owner as released (REQ-015/016) and pulse timeout=1 for one cycle.
REQ-027 With RR_TIMEOUT_EN defined, a revoked requester still asserting req SHALL be eligible again at lowest priority.
REQ-028 Without RR_TIMEOUT_EN: no counter SHALL be built, timeout SHALL be tied to 0, and grants are unbounded.

Verification
REQ-029 rst high 2 cycles, then req=4'b0100 -> gnt=0100, gnt_id=2, busy=1 one edge later; tok stays 0001.
REQ-030 req=4'b1111 held, each owner drops for one cycle on release -> grant order 0,1,2,3,0 with zero-gap handover; tok follows 0010,0100,1000,0001.
REQ-031 Owner 1 releases while req=4'b0011 re-asserted -> gnt=0001, not 0010.
REQ-032 rst asserted while gnt=1000 -> gnt=0, busy=0, tok=0001 on that edge; then req=1001 -> gnt=0001.
REQ-033 RR_TIMEOUT_EN, HOLD_MAX=4, req=0011 held constant -> requester 0 granted 4 cycles, timeout pulses, gnt=0010 on the same edge, then 4 cycles later back to 0001.
REQ-034 Without RR_TIMEOUT_EN, req=0001 held 300 cycles -> gnt=0001 throughout, timeout=0.

Source files
------------

// File: rtl/rr_token_arb_if.sv
// Request/grant bundle for rr_token_arb.
// slave  : arbiter side (takes requests, drives grant status)
// master : requester side
interface rr_token_arb_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport slave  (input req, output gnt, output gnt_id, output busy, output timeout);
  modport master (output req, input gnt, input gnt_id, input busy, input timeout);
endinterface

// File: rtl/rr_token_arb.sv
// rr_token_arb: 4-way round-robin token arbiter with hold-while-requested
// grants and zero-gap handover on release.
// Optional macro RR_TIMEOUT_EN: bounds each grant to HOLD_MAX cycles and
// pulses timeout when an owner is forcibly revoked.
module rr_token_arb #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic          ck,
  input  logic          rst,
  rr_token_arb_if.slave bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] tok_q, tok_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       rel;
  logic       force_rev;
  logic [2:0] sel;

  // Ring search from the token position; returns {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [3:0] t);
    logic [1:0] base;
    logic [1:0] idx;
    logic [2:0] res;
    res  = '0;
    base = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (t[i]) base = 2'(i);
    // Walk farthest-first so the nearest requester overwrites the result.
    for (int unsigned k = 4; k > 0; k--) begin
      idx = base + 2'(k - 1);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef RR_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q;
  assign force_rev = (hold_q == 8'(HOLD_MAX - 1)) && bus.req[gnt_id_q];
  assign bus.timeout = timeout_q;
`else
  assign force_rev   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign rel = !bus.req[gnt_id_q] || force_rev;

  // Next-state: new grant from IDLE, hold, or release-and-handover in GRANT.
  always_comb begin
    state_d  = state_q;
    tok_d    = tok_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    sel      = '0;
`ifdef RR_TIMEOUT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      IDLE: begin
        sel = pick(bus.req, tok_q);
        if (sel[2]) begin
          gnt_d    = 4'b0001 << sel[1:0];
          gnt_id_d = sel[1:0];
          busy_d   = 1'b1;
          state_d  = GRANT;
`ifdef RR_TIMEOUT_EN
          hold_d   = '0;
`endif
        end
      end
      default: begin
        if (rel) begin
          // Selection uses the advanced token, so the outgoing owner ranks last.
          tok_d = 4'b0001 << (gnt_id_q + 2'd1);
          sel   = pick(bus.req, tok_d);
          if (sel[2]) begin
            gnt_d    = 4'b0001 << sel[1:0];
            gnt_id_d = sel[1:0];
`ifdef RR_TIMEOUT_EN
            hold_d   = '0;
`endif
          end else begin
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end else begin
`ifdef RR_TIMEOUT_EN
          hold_d = hold_q + 8'd1;
`endif
        end
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q  <= IDLE;
      tok_q    <= 4'b0001;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tok_q    <= tok_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RR_TIMEOUT_EN
  // Hold counter and one-cycle revoke pulse.
  always_ff @(posedge ck) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= (state_q == GRANT) && force_rev;
    end
  end
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;

endmodule
